// File: rtl/bc_tx_msg_fetch.sv
// BC transmit message sequencer: fetches a descriptor and its data words from BC_TX_RAM
// port B and streams them to the encoder. Optional one-word prefetch: BC_TX_PREFETCH_EN.
module bc_tx_msg_fetch #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 40
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic [ADDR_W-1:0] BASE_ADDR,
   input  logic              ABORT,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic              RAM_REN,
   input  logic [DATA_W-1:0] RAM_DOUT,
   output logic [15:0]       WORD_DATA,
   output logic              WORD_SYNC,
   output logic              WORD_VALID,
   input  logic              WORD_READY
);

   typedef enum logic [2:0] {
      S_IDLE, S_DRD, S_DWT, S_CMD, S_DATA_RD, S_DATA_WT, S_DATA
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              ren_q, ren_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic              valid_q, valid_d, sync_q, sync_d;
   logic [15:0]       word_q, word_d;
   logic [5:0]        n_q, n_d, cnt_q, cnt_d;
   logic              rd_fire;
   logic              unused_dout;

   assign unused_dout = ^RAM_DOUT[DATA_W-2:16];

   // Data word count: mode codes carry one word only when receive with WC[4]=1.
   function automatic logic [5:0] calc_n(input logic [15:0] cmd);
      logic [4:0] sa, wc;
      sa = cmd[9:5];
      wc = cmd[4:0];
      if (sa == 5'd0 || sa == 5'h1F)
         calc_n = (!cmd[10] && wc[4]) ? 6'd1 : 6'd0;
      else if (cmd[10])
         calc_n = 6'd0;
      else
         calc_n = (wc == 5'd0) ? 6'd32 : {1'b0, wc};
   endfunction

`ifdef BC_TX_PREFETCH_EN
   logic        buf_v_q, buf_v_d, rd_v_q, rd_v_d, pf_issue, fire, free, last;
   logic [15:0] buf_q, buf_d;
   logic [5:0]  rd_cnt_q, rd_cnt_d;
   logic [1:0]  occ;

   // A read is issued only if output register plus buffer can absorb every word in flight.
   always_comb begin
      occ      = 2'(buf_v_q) + 2'(rd_v_q) + 2'(valid_q & ~WORD_READY);
      pf_issue = (state_q == S_CMD || state_q == S_DATA) && (rd_cnt_q < n_q) && (occ <= 2'd1);
      fire     = valid_q & WORD_READY;
      free     = ~valid_q | fire;
      last     = (state_q == S_CMD) ? (n_q == 6'd0) : (cnt_q + 6'd1 == n_q);
   end
   assign rd_fire = ren_q | pf_issue;
`else
   assign rd_fire = ren_q;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = rd_fire ? addr_q + ADDR_W'(1) : addr_q;
      ren_d   = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      valid_d = valid_q;
      sync_d  = sync_q;
      word_d  = word_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
`ifdef BC_TX_PREFETCH_EN
      buf_v_d  = buf_v_q;
      buf_d    = buf_q;
      rd_v_d   = pf_issue;
      rd_cnt_d = rd_cnt_q + 6'(pf_issue);
`endif
      unique case (state_q)
         S_IDLE: if (START && !ABORT) begin
            state_d = S_DRD;
            addr_d  = BASE_ADDR;
            ren_d   = 1'b1;
            cnt_d   = '0;
         end
         S_DRD: state_d = S_DWT;
         S_DWT: if (RAM_DOUT[DATA_W-1]) begin
            word_d  = RAM_DOUT[15:0];
            sync_d  = 1'b1;
            valid_d = 1'b1;
            n_d     = calc_n(RAM_DOUT[15:0]);
            state_d = S_CMD;
`ifdef BC_TX_PREFETCH_EN
            rd_cnt_d = '0;
            buf_v_d  = 1'b0;
`endif
         end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
         end
`ifdef BC_TX_PREFETCH_EN
         S_CMD, S_DATA: begin
            if (fire && state_q == S_DATA) cnt_d = cnt_q + 6'd1;
            if (fire && last) begin
               valid_d = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               if (fire) state_d = S_DATA;
               if (free) begin
                  if (buf_v_q) begin
                     word_d  = buf_q;
                     valid_d = 1'b1;
                     sync_d  = 1'b0;
                     buf_v_d = rd_v_q;
                     buf_d   = RAM_DOUT[15:0];
                  end else if (rd_v_q) begin
                     word_d  = RAM_DOUT[15:0];
                     valid_d = 1'b1;
                     sync_d  = 1'b0;
                  end else begin
                     valid_d = 1'b0;
                  end
               end else if (rd_v_q) begin
                  buf_v_d = 1'b1;
                  buf_d   = RAM_DOUT[15:0];
               end
            end
         end
         default: state_d = S_IDLE;
`else
         S_CMD: if (WORD_READY) begin
            valid_d = 1'b0;
            if (n_q == 6'd0) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               ren_d   = 1'b1;
               state_d = S_DATA_RD;
            end
         end
         S_DATA_RD: state_d = S_DATA_WT;
         S_DATA_WT: begin
            word_d  = RAM_DOUT[15:0];
            sync_d  = 1'b0;
            valid_d = 1'b1;
            state_d = S_DATA;
         end
         S_DATA: if (WORD_READY) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + 6'd1;
            if (cnt_q + 6'd1 == n_q) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               ren_d   = 1'b1;
               state_d = S_DATA_RD;
            end
         end
         default: state_d = S_IDLE;
`endif
      endcase
      if (ABORT && state_q != S_IDLE) begin
         state_d = S_IDLE;
         valid_d = 1'b0;
         ren_d   = 1'b0;
         done_d  = 1'b0;
         err_d   = 1'b0;
`ifdef BC_TX_PREFETCH_EN
         buf_v_d = 1'b0;
         rd_v_d  = 1'b0;
`endif
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         ren_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         sync_q  <= 1'b0;
         word_q  <= '0;
         n_q     <= '0;
         cnt_q   <= '0;
`ifdef BC_TX_PREFETCH_EN
         buf_v_q  <= 1'b0;
         buf_q    <= '0;
         rd_v_q   <= 1'b0;
         rd_cnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         ren_q   <= ren_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         sync_q  <= sync_d;
         word_q  <= word_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
`ifdef BC_TX_PREFETCH_EN
         buf_v_q  <= buf_v_d;
         buf_q    <= buf_d;
         rd_v_q   <= rd_v_d;
         rd_cnt_q <= rd_cnt_d;
`endif
      end
   end

   assign BUSY       = busy_q;
   assign DONE       = done_q;
   assign ERR        = err_q;
   assign RAM_ADDR   = addr_q;
   assign RAM_REN    = rd_fire;
   assign WORD_DATA  = word_q;
   assign WORD_SYNC  = sync_q;
   assign WORD_VALID = valid_q;

endmodule
